// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the common data bus among the ALU reservation-station/ALU pairs of the
// Tomasulo core. Each requester parks its finished result (ROB tag + data) in a
// one-entry holding register. A round-robin scheduler then broadcasts up to
// CDB_PORTS of the held results per cycle onto the tag-indexed CDB strobes.
// Requesters see back-pressure through req_ready while their holding register
// is occupied and not being drained.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (drops pending results, rr_ptr=0)
//   flush       synchronous mispredict squash (drops pending results)
//   req_valid   [NUM_REQ]          requester i presents a result
//   req_tag     [NUM_REQ][TAG_W]   destination ROB tag of that result
//   req_data    [NUM_REQ][32]      result data
//   req_ready   [NUM_REQ]          holding register i accepts this cycle
//   cdb_enable  [ROB_DEPTH]        registered broadcast strobe, one bit per tag
//   cdb_data    [ROB_DEPTH][32]    registered data at each broadcast tag index
//   grant_o     [NUM_REQ]          registered: requesters on the bus this cycle
//
// Latency: a result captured at edge E0 is selected from the holding register
// during the following cycle and appears on the bus after edge E1.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CDB_PORTS = 2,
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ-1:0][31:0]       req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ROB_DEPTH-1:0]           cdb_enable,
  output logic [ROB_DEPTH-1:0][31:0]     cdb_data,
  output logic [NUM_REQ-1:0]             grant_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(CDB_PORTS + 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] PORT_LIM  = CNT_W'(CDB_PORTS);

  // Holding register contents, gathered from the per-requester slices below.
  logic [NUM_REQ-1:0]            hold_v;
  logic [NUM_REQ-1:0][TAG_W-1:0] hold_tag;
  logic [NUM_REQ-1:0][31:0]      hold_data;

  // Scheduler state and combinational selection.
  logic [PTR_W-1:0]     rr_ptr_reg;
  logic [PTR_W-1:0]     rr_ptr_next;
  logic [NUM_REQ-1:0]   sel;
  logic                 sel_any;
  logic [ROB_DEPTH-1:0] tag_taken;
  logic [CNT_W-1:0]     sel_cnt;
  logic [PTR_W-1:0]     scan_idx;

  // Broadcast registers and their next values.
  logic [ROB_DEPTH-1:0]       cdb_enable_reg;
  logic [ROB_DEPTH-1:0]       cdb_enable_next;
  logic [ROB_DEPTH-1:0][31:0] cdb_data_reg;
  logic [ROB_DEPTH-1:0][31:0] cdb_data_next;
  logic [NUM_REQ-1:0]         grant_reg;

  // ---------------------------------------------------------------------------
  // Per-requester holding registers.
  // A slot that is being broadcast this cycle may be refilled at the same edge,
  // so ready is offered to an occupied slot when it is selected.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold
    logic        v_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [31:0] data_reg;
    logic        take;

    assign req_ready[gi] = ~rst & ~flush & (~v_reg | sel[gi]);
    assign take          = req_valid[gi] & req_ready[gi];

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        v_reg <= 1'b0;
      end else if (take) begin
        // Capture wins over the drain of the previous occupant.
        v_reg    <= 1'b1;
        tag_reg  <= req_tag[gi];
        data_reg <= req_data[gi];
      end else if (sel[gi]) begin
        v_reg <= 1'b0;
      end
    end

    assign hold_v[gi]    = v_reg;
    assign hold_tag[gi]  = tag_reg;
    assign hold_data[gi] = data_reg;
  end

  // ---------------------------------------------------------------------------
  // Round-robin selection.
  // Walk the slots starting at rr_ptr. Take every occupied slot until the bus
  // ports run out, but pass over a slot whose tag is already on the bus this
  // cycle: two writers to one tag index would collide, so the later one waits.
  // Skipped slots do not consume a port and the scan keeps going past them.
  // The pointer lands just after the last slot actually taken.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel         = '0;
    sel_any     = 1'b0;
    tag_taken   = '0;
    sel_cnt     = '0;
    scan_idx    = rr_ptr_reg;
    rr_ptr_next = rr_ptr_reg;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (hold_v[scan_idx] && (sel_cnt < PORT_LIM) &&
          !tag_taken[hold_tag[scan_idx]]) begin
        sel[scan_idx]                 = 1'b1;
        tag_taken[hold_tag[scan_idx]] = 1'b1;
        sel_cnt                       = sel_cnt + CNT_W'(1);
        sel_any                       = 1'b1;
        rr_ptr_next = (scan_idx == LAST_IDX) ? '0 : scan_idx + PTR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Broadcast image for the next cycle. Selected tags are distinct, so each
  // tag index has at most one writer; every other index reads as zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    cdb_enable_next = '0;
    cdb_data_next   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i]) begin
        cdb_enable_next[hold_tag[i]] = 1'b1;
        cdb_data_next[hold_tag[i]]   = hold_data[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers. flush and rst both squash the broadcast that would have
  // gone out at this edge, so nothing stale reaches the bus.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cdb_enable_reg <= '0;
      cdb_data_reg   <= '0;
      grant_reg      <= '0;
    end else begin
      cdb_enable_reg <= cdb_enable_next;
      cdb_data_reg   <= cdb_data_next;
      grant_reg      <= sel;
    end
  end

  // The pointer survives a flush; only reset returns it to slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (!flush && sel_any) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign cdb_enable = cdb_enable_reg;
  assign cdb_data   = cdb_data_reg;
  assign grant_o    = grant_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter. A behavioural model (per-requester
// pending slots, a scan order list and a set of tags already on the bus) runs
// alongside the DUT; a compare process checks every output on every falling
// edge. Directed scenarios pin the model with literal expectations, then a
// randomized phase with protocol-respecting requesters exercises the rest.
// Inputs change 2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int CDB_PORTS = 2;
  localparam int ROB_DEPTH = 8;
  localparam int TAG_W     = 3;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          flush;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0][31:0]      req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [ROB_DEPTH-1:0]          cdb_enable;
  logic [ROB_DEPTH-1:0][31:0]    cdb_data;
  logic [NUM_REQ-1:0]            grant_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .CDB_PORTS(CDB_PORTS),
    .ROB_DEPTH(ROB_DEPTH),
    .TAG_W    (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_enable(cdb_enable),
    .cdb_data  (cdb_data),
    .grant_o   (grant_o)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit          m_v    [NUM_REQ];
  int          m_tag  [NUM_REQ];
  logic [31:0] m_data [NUM_REQ];
  int          m_ptr = 0;
  bit          acc_last [NUM_REQ];

  logic [ROB_DEPTH-1:0]       e_en    = '0;
  logic [ROB_DEPTH-1:0][31:0] e_data  = '0;
  logic [NUM_REQ-1:0]         e_grant = '0;

  // Which pending results go on the bus now, and the last one taken in scan order.
  task automatic model_pick(output logic [NUM_REQ-1:0] pick, output int last);
    int order[$];
    bit on_bus[ROB_DEPTH];
    int taken;
    int r;
    pick  = '0;
    last  = -1;
    taken = 0;
    foreach (on_bus[t]) on_bus[t] = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) order.push_back((m_ptr + k) % NUM_REQ);
    foreach (order[j]) begin
      r = order[j];
      if (m_v[r] && taken < CDB_PORTS && !on_bus[m_tag[r]]) begin
        pick[r]           = 1'b1;
        on_bus[m_tag[r]]  = 1'b1;
        taken++;
        last = r;
      end
    end
  endtask

  task automatic model_ready(output logic [NUM_REQ-1:0] rdy);
    logic [NUM_REQ-1:0] pick;
    int last;
    model_pick(pick, last);
    for (int i = 0; i < NUM_REQ; i++)
      rdy[i] = !rst && !flush && (!m_v[i] || pick[i]);
  endtask

  task automatic model_step();
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] rdy;
    int last;
    model_pick(pick, last);
    model_ready(rdy);
    for (int i = 0; i < NUM_REQ; i++) begin
      acc_last[i] = req_valid[i] && rdy[i];
      if (req_valid[i]) assert (int'(req_tag[i]) < ROB_DEPTH);
    end
    e_en    = '0;
    e_data  = '0;
    e_grant = '0;
    if (rst || flush) begin
      for (int i = 0; i < NUM_REQ; i++) m_v[i] = 1'b0;
      if (rst) m_ptr = 0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pick[i]) begin
          e_en[m_tag[i]]   = 1'b1;
          e_data[m_tag[i]] = m_data[i];
          e_grant[i]       = 1'b1;
          m_v[i]           = 1'b0;
        end
      end
      if (last >= 0) m_ptr = (last + 1) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_last[i]) begin
          m_v[i]    = 1'b1;
          m_tag[i]  = int'(req_tag[i]);
          m_data[i] = req_data[i];
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      m_v[i] = 1'b0; m_tag[i] = 0; m_data[i] = '0; acc_last[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Comparison helper and per-cycle compare process
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_cycle();
    logic [NUM_REQ-1:0] rdy;
    model_ready(rdy);
    check("cyc_cdb_enable", 256'(cdb_enable), 256'(e_en));
    check("cyc_cdb_data",   256'(cdb_data),   256'(e_data));
    check("cyc_grant",      256'(grant_o),    256'(e_grant));
    check("cyc_req_ready",  256'(req_ready),  256'(rdy));
    if (cdb_enable != '0)
      $display("bcast t=%0t grant=%b enable=%b", $time, grant_o, cdb_enable);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_cycle();
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
  endtask

  logic [NUM_REQ-1:0] fair_exp [6];

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    idle_inputs();
    fair_exp[0] = 4'b0011; fair_exp[1] = 4'b0101; fair_exp[2] = 4'b0110;
    fair_exp[3] = 4'b0011; fair_exp[4] = 4'b0101; fair_exp[5] = 4'b0110;

    // Reset state
    step(); step();
    check("rst_cdb_enable", 256'(cdb_enable), 256'(0));
    check("rst_grant",      256'(grant_o),    256'(0));
    check("rst_cdb_data",   256'(cdb_data),   256'(0));
    check("rst_ready_low",  256'(req_ready),  256'(0));
    rst = 1'b0;
    #1;
    check("rst_ready_after", 256'(req_ready), 256'(4'hF));
    $display("scenario reset done");

    // Four simultaneous results, tags 0..3, pointer at 0
    req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tag[i]  = TAG_W'(i);
      req_data[i] = 32'h1000 + 32'(i);
    end
    step();
    req_valid = '0;
    #1;
    check("four_ready_sel", 256'(req_ready), 256'(4'b0011));
    step();
    check("four_enable_1", 256'(cdb_enable), 256'(8'h03));
    check("four_grant_1",  256'(grant_o),    256'(4'b0011));
    step();
    check("four_enable_2", 256'(cdb_enable), 256'(8'h0C));
    check("four_grant_2",  256'(grant_o),    256'(4'b1100));
    check("four_data_3",   256'(cdb_data[3]), 256'(32'h1003));
    step();
    check("four_idle", 256'(cdb_enable), 256'(0));
    $display("scenario four-way done");

    // Round-robin fairness: requesters 0..2 refill every cycle
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      req_tag[i]  = TAG_W'(i);
      req_data[i] = 32'h2000 + 32'(i);
    end
    step();
    for (int n = 0; n < 6; n++) begin
      step();
      check($sformatf("fair_grant_%0d", n), 256'(grant_o), 256'(fair_exp[n]));
    end
    req_valid = '0;
    step(); step(); step();
    $display("scenario fairness done");

    // Tag collision: both carry tag 5, pointer reset to 0 first
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid   = 4'b0011;
    req_tag[0]  = 3'd5; req_data[0] = 32'hAA;
    req_tag[1]  = 3'd5; req_data[1] = 32'h55;
    step();
    req_valid = '0;
    step();
    check("coll_enable_1", 256'(cdb_enable),  256'(8'h20));
    check("coll_data_1",   256'(cdb_data[5]), 256'(32'hAA));
    check("coll_grant_1",  256'(grant_o),     256'(4'b0001));
    step();
    check("coll_data_2",   256'(cdb_data[5]), 256'(32'h55));
    check("coll_grant_2",  256'(grant_o),     256'(4'b0010));
    step();
    $display("scenario collision done");

    // Single result: tag 3, data 0xB
    req_valid   = 4'b0001;
    req_tag[0]  = 3'd3;
    req_data[0] = 32'h0000000B;
    step();
    req_valid = '0;
    check("single_no_bypass", 256'(cdb_enable), 256'(0));
    step();
    check("single_enable", 256'(cdb_enable),  256'(8'b00001000));
    check("single_data",   256'(cdb_data[3]), 256'(32'hB));
    check("single_grant",  256'(grant_o),     256'(4'b0001));
    step();
    check("single_after_en",    256'(cdb_enable), 256'(0));
    check("single_after_data",  256'(cdb_data),   256'(0));
    check("single_after_grant", 256'(grant_o),    256'(0));
    $display("scenario single done");

    // Flush with three results pending
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      req_tag[i]  = TAG_W'(i + 1);
      req_data[i] = 32'h3000 + 32'(i);
    end
    step();
    req_valid = '0;
    flush     = 1'b1;
    #1;
    check("flush_ready_low", 256'(req_ready), 256'(0));
    step();
    flush = 1'b0;
    #1;
    check("flush_enable", 256'(cdb_enable), 256'(0));
    check("flush_grant",  256'(grant_o),    256'(0));
    check("flush_ready",  256'(req_ready),  256'(4'hF));
    step();
    check("flush_no_stale_1", 256'(cdb_enable), 256'(0));
    step();
    check("flush_no_stale_2", 256'(cdb_enable), 256'(0));
    $display("scenario flush done");

    // Reset in the middle of a drain, held two cycles
    req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tag[i]  = TAG_W'(i + 4);
      req_data[i] = 32'h4000 + 32'(i);
    end
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    #1;
    check("rstmid_ready_low", 256'(req_ready), 256'(0));
    step(); step();
    rst = 1'b0;
    #1;
    check("rstmid_enable", 256'(cdb_enable), 256'(0));
    check("rstmid_data",   256'(cdb_data),   256'(0));
    check("rstmid_grant",  256'(grant_o),    256'(0));
    check("rstmid_ready",  256'(req_ready),  256'(4'hF));
    req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tag[i]  = TAG_W'(i);
      req_data[i] = 32'h5000 + 32'(i);
    end
    step();
    req_valid = '0;
    step();
    check("rstmid_grant_1", 256'(grant_o), 256'(4'b0011));
    step();
    check("rstmid_grant_2", 256'(grant_o), 256'(4'b1100));
    step();
    $display("scenario reset-mid done");

    // Randomized traffic with occasional flush/reset pulses
    for (int c = 0; c < 1500; c++) begin
      int r;
      r     = int'($urandom_range(0, 99));
      rst   = (r < 1);
      flush = (r >= 1 && r < 4);
      for (int i = 0; i < NUM_REQ; i++) begin
        // A presented but not yet accepted request stays untouched.
        if (!req_valid[i] || acc_last[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 55);
          req_tag[i]   = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
          req_data[i]  = $urandom;
        end
      end
      step();
    end
    rst   = 1'b0;
    flush = 1'b0;
    idle_inputs();
    step(); step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
